// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file types and constants for the writeback path
package regfile_pkg;
  localparam int REG_COUNT = 32;
  localparam logic [4:0] ZERO_REG = 5'd31;
  typedef logic [4:0] reg_addr_t;
  typedef logic [63:0] reg_data_t;
  typedef struct packed {
    logic valid;
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;
  function automatic logic [REG_COUNT-1:0] onehot(input reg_addr_t a);
    return REG_COUNT'(1) << a;
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter; the pointer moves past each grantee
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          hold,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic [IW-1:0] ptr;
  logic found;
  int j;
  always_comb begin
    grant = '0;
    grant_idx = '0;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j] && !hold && reset_n) begin
        found = 1'b1;
        grant[j] = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr <= '0;
    else if (found) ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the regfile write port among NREQ writeback sources
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               hold,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic               we3,
  output logic [AW-1:0]      wa3,
  output logic [DW-1:0]      wd3,
  output logic [31:0]        pending,
  output logic [15:0]        grant_cnt
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0] grant_idx;
  logic [AW-1:0] addr_a [NREQ];
  logic [DW-1:0] data_a [NREQ];
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic xfer, live;
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*AW +: AW];
    assign data_a[i] = req_data[i*DW +: DW];
  end
  rr_arbiter #(.N(NREQ)) u_arb (
    .clk(clk),
    .reset_n(reset_n),
    .hold(hold),
    .req(req_valid),
    .grant(req_ready),
    .grant_idx(grant_idx)
  );
  assign xfer = |req_ready;
  assign sel_addr = addr_a[grant_idx];
  assign sel_data = data_a[grant_idx];
  // writes to the hardwired zero register are accepted but never reach the regfile
  assign live = xfer && (sel_addr != AW'(ZERO_REG));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
      pending <= '0;
      grant_cnt <= '0;
    end else begin
      we3 <= live;
      pending <= live ? onehot(reg_addr_t'(sel_addr)) : '0;
      if (xfer) begin
        wa3 <= sel_addr;
        wd3 <= sel_data;
        grant_cnt <= grant_cnt + 16'd1;
      end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of arbitration, output stage, X31 and wrap
module tb_regfile_wb_arbiter;
  localparam int NREQ = 2, DW = 64, AW = 5;
  logic clk = 1'b0;
  logic reset_n, hold;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic [31:0] pending;
  logic [15:0] grant_cnt;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .pending(pending), .grant_cnt(grant_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    repeat (2) @(negedge clk);
    check("rst_we3", 64'(we3), 0);
    check("rst_wa3", 64'(wa3), 0);
    check("rst_wd3", wd3, 0);
    check("rst_pending", 64'(pending), 0);
    check("rst_cnt", 64'(grant_cnt), 0);
    req_valid = 2'b01;
    #1 check("rst_ready_forced", 64'(req_ready), 0);
    reset_n = 1'b1;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    req_valid = 2'b01; req_addr[4:0] = 5'd3; req_data[63:0] = 64'hAA;
    #1 check("mid_ready", 64'(req_ready), 1);
    reset_n = 1'b0;
    #1 check("mid_ready_rst", 64'(req_ready), 0);
    @(negedge clk);
    check("mid_we3", 64'(we3), 0);
    check("mid_pending", 64'(pending), 0);
    check("mid_cnt", 64'(grant_cnt), 0);
    req_valid = '0;
    reset_n = 1'b1;
    req_valid = 2'b11;
    #1 check("ptr0_after_rst", 64'(req_ready), 1);
    req_valid = 2'b01; req_addr[4:0] = 5'd5; req_data[63:0] = 64'h1234;
    #1 check("single_ready", 64'(req_ready), 1);
    @(negedge clk);
    req_valid = '0;
    check("single_we3", 64'(we3), 1);
    check("single_wa3", 64'(wa3), 5);
    check("single_wd3", wd3, 64'h1234);
    check("single_pending", 64'(pending), 64'h20);
    check("single_cnt", 64'(grant_cnt), 1);
    @(negedge clk);
    check("single_we3_off", 64'(we3), 0);
    check("single_pending_off", 64'(pending), 0);
    req_valid = 2'b10; req_addr[9:5] = 5'd31; req_data[127:64] = 64'hFF;
    #1 check("x31_ready", 64'(req_ready), 2);
    @(negedge clk);
    req_valid = '0;
    check("x31_we3", 64'(we3), 0);
    check("x31_pending", 64'(pending), 0);
    check("x31_cnt", 64'(grant_cnt), 2);
    check("x31_wa3", 64'(wa3), 31);
    req_addr = {5'd2, 5'd1};
    req_data = {64'h22, 64'h11};
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("rr_ready%0d", i), 64'(req_ready), (i % 2) ? 2 : 1);
      @(negedge clk);
      check($sformatf("rr_we3_%0d", i), 64'(we3), 1);
      check($sformatf("rr_wa3_%0d", i), 64'(wa3), (i % 2) ? 2 : 1);
      check($sformatf("rr_wd3_%0d", i), wd3, (i % 2) ? 64'h22 : 64'h11);
    end
    check("rr_cnt", 64'(grant_cnt), 6);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("hold_ready%0d", i), 64'(req_ready), 0);
      @(negedge clk);
      check($sformatf("hold_we3_%0d", i), 64'(we3), 0);
    end
    check("hold_cnt", 64'(grant_cnt), 6);
    hold = 1'b0;
    #1 check("resume_ready", 64'(req_ready), 1);
    @(negedge clk);
    check("resume_wa3", 64'(wa3), 1);
    check("resume_cnt", 64'(grant_cnt), 7);
    req_valid = 2'b01;
    repeat (65528) @(negedge clk);
    check("wrap_pre", 64'(grant_cnt), 64'hFFFF);
    @(negedge clk);
    check("wrap_zero", 64'(grant_cnt), 0);
    req_valid = '0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
